// File: rtl/control_unit.sv
// control_unit: multicycle MIPS control FSM; outputs decoded from state (BRANCH PCWrite also follows Zero).
// Latency 5-8 cycles per instruction, no backpressure; CONTROL_UNIT_OVERFLOW_EXC_EN adds the overflow EXC state.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Func,
    input  logic       Overflow,
    input  logic       Zero,
    input  logic       LT,
    output logic       PCWrite,
    output logic       MemOp,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       WriteA,
    output logic       WriteB,
    output logic       WriteALUOut,
    output logic       EPCWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] PCSource,
    output logic [2:0] SrcAddressMem,
    output logic [2:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [2:0] MemToReg,
    output logic [2:0] RegDst
);

    typedef enum logic [4:0] {
        ST_RESET, ST_SP_INIT, ST_FETCH0, ST_FETCH1, ST_FETCH2, ST_DECODE,
        ST_R_EXEC, ST_R_WB, ST_SLT, ST_JR, ST_I_EXEC, ST_I_WB,
        ST_ADDR, ST_MEM_RD0, ST_MEM_RD1, ST_LW_WB, ST_MEM_WR,
        ST_BRANCH, ST_JUMP, ST_EXC
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [2:0] ALU_LOAD = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_CMP  = 3'b111;

    state_t     state_q, state_d;
    logic [2:0] alu_sel_q, alu_sel_d;
    logic       bne_q, bne_d;
    logic       store_q, store_d;

    // Instruction class is latched at DECODE so later states decode from registered state only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RESET;
            alu_sel_q <= ALU_ADD;
            bne_q     <= 1'b0;
            store_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_sel_q <= alu_sel_d;
            bne_q     <= bne_d;
            store_q   <= store_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        alu_sel_d     = alu_sel_q;
        bne_d         = bne_q;
        store_d       = store_q;
        PCWrite       = 1'b0;
        MemOp         = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        WriteA        = 1'b0;
        WriteB        = 1'b0;
        WriteALUOut   = 1'b0;
        EPCWrite      = 1'b0;
        ALUSrcA       = 2'b00;
        PCSource      = 2'b00;
        SrcAddressMem = 3'b000;
        ALUSrcB       = 3'b000;
        ALUOp         = ALU_LOAD;
        MemToReg      = 3'b000;
        RegDst        = 3'b000;

        case (state_q)
            ST_RESET: state_d = ST_SP_INIT;
            ST_SP_INIT: begin
                RegWrite = 1'b1;
                RegDst   = 3'b010;
                MemToReg = 3'b111;
                state_d  = ST_FETCH0;
            end
            ST_FETCH0: state_d = ST_FETCH1;
            ST_FETCH1: state_d = ST_FETCH2;
            ST_FETCH2: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 3'b001;
                ALUOp   = ALU_ADD;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                WriteA      = 1'b1;
                WriteB      = 1'b1;
                WriteALUOut = 1'b1;
                ALUSrcB     = 3'b011;
                ALUOp       = ALU_ADD;
                state_d     = ST_FETCH0;
                case (OpCode)
                    OP_RTYPE: begin
                        case (Func)
                            FN_ADD: begin state_d = ST_R_EXEC; alu_sel_d = ALU_ADD; end
                            FN_SUB: begin state_d = ST_R_EXEC; alu_sel_d = ALU_SUB; end
                            FN_AND: begin state_d = ST_R_EXEC; alu_sel_d = ALU_AND; end
                            FN_SLT: state_d = ST_SLT;
                            FN_JR:  state_d = ST_JR;
                            default: state_d = ST_FETCH0;
                        endcase
                    end
                    OP_ADDI: state_d = ST_I_EXEC;
                    OP_LW:   begin state_d = ST_ADDR; store_d = 1'b0; end
                    OP_SW:   begin state_d = ST_ADDR; store_d = 1'b1; end
                    OP_BEQ:  begin state_d = ST_BRANCH; bne_d = 1'b0; end
                    OP_BNE:  begin state_d = ST_BRANCH; bne_d = 1'b1; end
                    OP_J:    state_d = ST_JUMP;
                    default: state_d = ST_FETCH0;
                endcase
            end
            ST_R_EXEC: begin
                ALUSrcA     = 2'b01;
                ALUOp       = alu_sel_q;
                WriteALUOut = 1'b1;
                state_d     = ST_R_WB;
`ifdef CONTROL_UNIT_OVERFLOW_EXC_EN
                if (Overflow && (alu_sel_q != ALU_AND)) begin
                    WriteALUOut = 1'b0;
                    state_d     = ST_EXC;
                end
`endif
            end
            ST_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 3'b001;
                state_d  = ST_FETCH0;
            end
            ST_SLT: begin
                ALUOp    = ALU_CMP;
                RegWrite = 1'b1;
                RegDst   = 3'b001;
                MemToReg = 3'b110;
                state_d  = ST_FETCH0;
            end
            ST_JR: begin
                ALUSrcA = 2'b01;
                PCWrite = 1'b1;
                state_d = ST_FETCH0;
            end
            ST_I_EXEC: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 3'b010;
                ALUOp       = ALU_ADD;
                WriteALUOut = 1'b1;
                state_d     = ST_I_WB;
`ifdef CONTROL_UNIT_OVERFLOW_EXC_EN
                if (Overflow) begin
                    WriteALUOut = 1'b0;
                    state_d     = ST_EXC;
                end
`endif
            end
            ST_I_WB: begin
                RegWrite = 1'b1;
                state_d  = ST_FETCH0;
            end
            ST_ADDR: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 3'b010;
                ALUOp       = ALU_ADD;
                WriteALUOut = 1'b1;
                state_d     = store_q ? ST_MEM_WR : ST_MEM_RD0;
            end
            ST_MEM_RD0: begin
                SrcAddressMem = 3'b001;
                state_d       = ST_MEM_RD1;
            end
            ST_MEM_RD1: begin
                SrcAddressMem = 3'b001;
                state_d       = ST_LW_WB;
            end
            ST_LW_WB: begin
                RegWrite = 1'b1;
                MemToReg = 3'b001;
                state_d  = ST_FETCH0;
            end
            ST_MEM_WR: begin
                SrcAddressMem = 3'b001;
                MemOp         = 1'b1;
                state_d       = ST_FETCH0;
            end
            ST_BRANCH: begin
                ALUSrcA  = 2'b01;
                ALUOp    = ALU_SUB;
                PCSource = 2'b01;
                PCWrite  = bne_q ? ~Zero : Zero;
                state_d  = ST_FETCH0;
            end
            ST_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                state_d  = ST_FETCH0;
            end
`ifdef CONTROL_UNIT_OVERFLOW_EXC_EN
            ST_EXC: begin
                EPCWrite = 1'b1;
                PCSource = 2'b11;
                PCWrite  = 1'b1;
                state_d  = ST_FETCH0;
            end
`endif
            default: state_d = ST_FETCH0;
        endcase
    end

    // LT only feeds the datapath's LT32 mux input; Overflow is ignored without the exception option.
`ifdef CONTROL_UNIT_OVERFLOW_EXC_EN
    logic unused_inputs;
    assign unused_inputs = LT;
`else
    logic unused_inputs;
    assign unused_inputs = LT ^ Overflow;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed and random instructions checked per cycle against a trace model.
module tb_control_unit;

`ifdef CONTROL_UNIT_OVERFLOW_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write, mem_op, ir_write, reg_write, write_a, write_b, write_alu_out, epc_write;
        logic [1:0] alu_src_a, pc_source;
        logic [2:0] src_addr_mem, alu_src_b, alu_op, mem_to_reg, reg_dst;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OpCode = '0, Func = '0;
    logic       Overflow = 1'b0, Zero = 1'b0, LT = 1'b0;
    logic       PCWrite, MemOp, IRWrite, RegWrite, WriteA, WriteB, WriteALUOut, EPCWrite;
    logic [1:0] ALUSrcA, PCSource;
    logic [2:0] SrcAddressMem, ALUSrcB, ALUOp, MemToReg, RegDst;

    int n_checks = 0;
    int n_err = 0;
    ctl_t exp_q[$];
    ctl_t obs;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Func(Func),
        .Overflow(Overflow), .Zero(Zero), .LT(LT),
        .PCWrite(PCWrite), .MemOp(MemOp), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .WriteA(WriteA), .WriteB(WriteB), .WriteALUOut(WriteALUOut), .EPCWrite(EPCWrite),
        .ALUSrcA(ALUSrcA), .PCSource(PCSource), .SrcAddressMem(SrcAddressMem),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemToReg(MemToReg), .RegDst(RegDst)
    );

    assign obs = '{PCWrite, MemOp, IRWrite, RegWrite, WriteA, WriteB, WriteALUOut, EPCWrite,
                   ALUSrcA, PCSource, SrcAddressMem, ALUSrcB, ALUOp, MemToReg, RegDst};

    task automatic chk(input string tag, input ctl_t got, input ctl_t want);
        n_checks++;
        assert (got === want)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Expected per-cycle strobe trace of one instruction, from FETCH0 through its last state.
    function automatic void build(input logic [5:0] op, input logic [5:0] fn, input logic zero, input logic ovf);
        ctl_t c;
        ctl_t exc;
        bit   trap;
        exp_q.delete();
        c = '0;
        exp_q.push_back(c);
        exp_q.push_back(c);
        c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 3'b001; c.alu_op = 3'b001;
        exp_q.push_back(c);
        c = '0; c.write_a = 1; c.write_b = 1; c.write_alu_out = 1; c.alu_src_b = 3'b011; c.alu_op = 3'b001;
        exp_q.push_back(c);
        exc = '0; exc.epc_write = 1; exc.pc_source = 2'b11; exc.pc_write = 1;
        trap = EXC_EN && ovf;
        c = '0;
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            c.alu_src_a = 2'b01;
            c.alu_op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
            if (fn == 6'h24) trap = 0;
            c.write_alu_out = !trap;
            exp_q.push_back(c);
            c = '0; c.reg_write = 1; c.reg_dst = 3'b001;
            exp_q.push_back(trap ? exc : c);
        end else if (op == 6'h00 && fn == 6'h2A) begin
            c.alu_op = 3'b111; c.reg_write = 1; c.reg_dst = 3'b001; c.mem_to_reg = 3'b110;
            exp_q.push_back(c);
        end else if (op == 6'h00 && fn == 6'h08) begin
            c.alu_src_a = 2'b01; c.pc_write = 1;
            exp_q.push_back(c);
        end else if (op == 6'h08) begin
            c.alu_src_a = 2'b01; c.alu_src_b = 3'b010; c.alu_op = 3'b001; c.write_alu_out = !trap;
            exp_q.push_back(c);
            c = '0; c.reg_write = 1;
            exp_q.push_back(trap ? exc : c);
        end else if (op == 6'h23 || op == 6'h2B) begin
            c.alu_src_a = 2'b01; c.alu_src_b = 3'b010; c.alu_op = 3'b001; c.write_alu_out = 1;
            exp_q.push_back(c);
            c = '0; c.src_addr_mem = 3'b001;
            if (op == 6'h2B) begin
                c.mem_op = 1;
                exp_q.push_back(c);
            end else begin
                exp_q.push_back(c);
                exp_q.push_back(c);
                c = '0; c.reg_write = 1; c.mem_to_reg = 3'b001;
                exp_q.push_back(c);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            c.alu_src_a = 2'b01; c.alu_op = 3'b010; c.pc_source = 2'b01;
            c.pc_write = (op == 6'h04) ? zero : !zero;
            exp_q.push_back(c);
        end else if (op == 6'h02) begin
            c.pc_source = 2'b10; c.pc_write = 1;
            exp_q.push_back(c);
        end
    endfunction

    // Called just after a posedge or mid-cycle; leaves time at posedge+1 in FETCH0.
    task automatic do_reset(input string tag);
        ctl_t sp;
        reset = 1'b0;
        #1;
        chk({tag, "_async_zero"}, obs, '0);
        @(posedge clk); #1;
        chk({tag, "_held_zero"}, obs, '0);
        reset = 1'b1;
        @(negedge clk);
        chk({tag, "_release_zero"}, obs, '0);
        @(posedge clk); #1;
        sp = '0; sp.reg_write = 1; sp.reg_dst = 3'b010; sp.mem_to_reg = 3'b111;
        @(negedge clk);
        chk({tag, "_sp_init"}, obs, sp);
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic zero, input logic ovf, input int abort_at);
        int n;
        build(op, fn, zero, ovf);
        n = exp_q.size();
        OpCode = op; Func = fn; Zero = zero; Overflow = ovf;
        for (int i = 0; i < n; i++) begin
            LT = 1'($urandom);
            @(negedge clk);
            chk($sformatf("%s_c%0d", name, i + 1), obs, exp_q[i]);
            if (i == abort_at) begin
                #1;
                do_reset({name, "_abort"});
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        logic [5:0] ops [8];
        logic [5:0] fns [6];
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h2A, 6'h08, 6'h11};
        #2;
        do_reset("por");

        run_instr("add",     6'h00, 6'h20, 0, 0, -1);
        run_instr("sub",     6'h00, 6'h22, 1, 0, -1);
        run_instr("and_ovf", 6'h00, 6'h24, 0, 1, -1);
        run_instr("slt",     6'h00, 6'h2A, 0, 0, -1);
        run_instr("jr",      6'h00, 6'h08, 0, 0, -1);
        run_instr("addi",    6'h08, 6'h00, 0, 0, -1);
        run_instr("addi_ov", 6'h08, 6'h00, 0, 1, -1);
        run_instr("add_ov",  6'h00, 6'h20, 0, 1, -1);
        run_instr("lw",      6'h23, 6'h00, 0, 0, -1);
        run_instr("sw",      6'h2B, 6'h00, 0, 0, -1);
        run_instr("beq_z1",  6'h04, 6'h00, 1, 0, -1);
        run_instr("beq_z0",  6'h04, 6'h00, 0, 0, -1);
        run_instr("bne_z1",  6'h05, 6'h00, 1, 0, -1);
        run_instr("bne_z0",  6'h05, 6'h00, 0, 0, -1);
        run_instr("j",       6'h02, 6'h00, 0, 0, -1);
        run_instr("unk_op",  6'h3F, 6'h20, 0, 0, -1);
        run_instr("unk_fn",  6'h00, 6'h3F, 0, 0, -1);
        run_instr("add_after_nop", 6'h00, 6'h20, 0, 0, -1);
        run_instr("sw_abort", 6'h2B, 6'h00, 0, 0, 5);
        run_instr("lw_after_abort", 6'h23, 6'h00, 0, 0, -1);
        run_instr("lw_abort_dec", 6'h23, 6'h00, 0, 0, 3);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 7)];
                fn = fns[$urandom_range(0, 5)];
            end
            run_instr($sformatf("rnd%0d_op%h_fn%h", k, op, fn), op, fn,
                      1'($urandom), 1'($urandom),
                      ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL run on one clock and use an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: system clock, rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 Port OpCode, input, 6 bits: IR[31:26].
REQ-005 Port Func, input, 6 bits: IR[5:0].
REQ-006 Port Overflow, Zero, LT, input, 1 bit each: ALU flags, combinational, valid in the same cycle.
REQ-007 Ports PCWrite, MemOp, IRWrite, RegWrite, WriteA, WriteB, WriteALUOut, EPCWrite, output, 1 bit each: load/write strobes (MemOp 1 = write).
REQ-008 Ports ALUSrcA and PCSource, output, 2 bits each: mux selects.
REQ-009 Ports SrcAddressMem, ALUSrcB, ALUOp, MemToReg, RegDst, output, 3 bits each: mux selects and ALU operation.

Function
REQ-010 Outputs SHALL be Moore-decoded from state, except PCWrite in BRANCH, which also depends on Zero.
REQ-011 Unlisted outputs SHALL be 0 in every state.
REQ-012 ALUOp: 000 load A, 001 add, 010 sub, 011 and, 111 compare.
REQ-013 ALUSrcA: 00 PC, 01 A.
REQ-014 ALUSrcB: 000 B, 001 const 4, 010 imm16, 011 imm16<<2.
REQ-015 PCSource: 00 ALUResult, 01 ALUOut, 10 jump, 11 vector 32'h000000FF.
REQ-016 MemToReg: 000 ALUOut, 001 MemOut, 110 LT32, 111 const 227.
REQ-017 RegDst: 000 rt, 001 rd, 010 reg 29.
REQ-018 SrcAddressMem: 000 PC, 001 ALUOut.
REQ-019 State SP_INIT: RegWrite=1, RegDst=010, MemToReg=111; next is FETCH0.
REQ-020 FETCH0: address PC, read; next FETCH1.
REQ-021 FETCH1: memory wait; next FETCH2.
REQ-022 FETCH2: IRWrite=1, PCWrite=1, PCSource=00, ALUSrcA=00, ALUSrcB=001, ALUOp=001; next DECODE.
REQ-023 DECODE: WriteA=WriteB=1, WriteALUOut=1, ALUSrcA=00, ALUSrcB=011, ALUOp=001; next state selected by OpCode.
REQ-024 R-type (OpCode 0): Func 0x20 add, 0x22 sub, 0x24 and go to R_EXEC (ALUSrcA=01, ALUSrcB=000, WriteALUOut=1), then R_WB (RegWrite, RegDst=001, MemToReg=000).
REQ-025 Func 0x2A slt: SLT state; ALUOp=111, RegWrite, RegDst=001, MemToReg=110.
REQ-026 Func 0x08 jr: JR state; ALUOp=000, ALUSrcA=01, PCSource=00, PCWrite=1.
REQ-027 addi (0x08): I_EXEC (A+imm16), then I_WB (RegDst=000).
REQ-028 lw (0x23): ADDR, then MEM_RD0, then MEM_RD1, then LW_WB (MemToReg=001, RegDst=000).
REQ-029 sw (0x2B): ADDR, then MEM_WR (SrcAddressMem=001, MemOp=1).
REQ-030 beq (0x04): BRANCH; sub A-B, PCSource=01, PCWrite=Zero.
REQ-031 bne (0x05): BRANCH; same as beq, PCWrite=~Zero.
REQ-032 j (0x02): JUMP; PCSource=10, PCWrite=1.
REQ-033 Any unlisted OpCode/Func SHALL execute as a NOP: DECODE returns to FETCH0.
REQ-034 The last state of every instruction SHALL return to FETCH0.
REQ-035 Latency from FETCH0 to the next FETCH0 SHALL be: R-type and addi 6 cycles, slt/jr/beq/bne/j 5, lw 8, sw 6.

Reset
REQ-036 reset=0 SHALL force state RESET immediately, regardless of clk.
REQ-037 While reset=0, all outputs SHALL be 0 (MemOp=0, so no memory write).
REQ-038 On the first rising edge with reset=1, the state SHALL go from RESET to SP_INIT.
REQ-039 Reset asserted during any state, including MEM_WR, SHALL abort the instruction with no further strobes.

Configuration
REQ-040 Macro CONTROL_UNIT_OVERFLOW_EXC_EN SHALL enable overflow exception handling.
REQ-041 With CONTROL_UNIT_OVERFLOW_EXC_EN defined, Overflow=1 in R_EXEC (add/sub) or I_EXEC SHALL suppress WriteALUOut and go to EXC.
REQ-042 EXC: EPCWrite=1, PCSource=11, PCWrite=1; next FETCH0; the destination register is not written.
REQ-043 With CONTROL_UNIT_OVERFLOW_EXC_EN undefined, Overflow SHALL be ignored, the EXC state SHALL not exist, and EPCWrite SHALL be tied to 0.

Verification
REQ-044 Reset release: reset 0->1 -> SP_INIT cycle shows RegWrite=1, RegDst=010, MemToReg=111, then FETCH0 with SrcAddressMem=000, MemOp=0.
REQ-045 add: OpCode=0, Func=0x20 -> IRWrite pulses at cycle 3, RegWrite=1 with RegDst=001 at cycle 6, FETCH0 at cycle 7.
REQ-046 lw: OpCode=0x23 -> SrcAddressMem=001 in cycles 6-7, RegWrite with MemToReg=001 at cycle 8; sw: OpCode=0x2B -> MemOp=1 for exactly one cycle (cycle 6).
REQ-047 beq with Zero=1 -> PCWrite=1, PCSource=01 in cycle 5; with Zero=0 -> PCWrite=0; bne gives the inverse.
REQ-048 Overflow=1 during addi R/I_EXEC with the macro defined -> EXC with EPCWrite=1 and PCSource=11, no RegWrite; with the macro undefined -> RegWrite occurs normally.
REQ-049 Unknown OpCode 0x3F -> FETCH0 after DECODE, with zero write strobes; reset=0 asserted mid MEM_WR -> MemOp drops asynchronously the same cycle.
